// File: rtl/ctl_hs_fifo.sv
// Purpose : req/ack handshake buffer between a self-timed producer and consumer, DEPTH words deep.
// Latency : empty buffer, in_req_i -> in_ack_o is SYNC_STAGES+1 edges; push -> out_req_o is 1 more edge.
// Backpress: when full, a pending push is held (in_ack_o frozen) until an edge where count<DEPTH or a pop occurs.
//
// Ports
//   clk_i       clock, all state on the rising edge
//   rst_ni      asynchronous active-low reset; release is expected to be synchronous to clk_i
//   in_req_i    producer request (4-phase level or 2-phase transition, per PROTO)
//   in_data_i   producer data, stable while the request is pending
//   in_ack_o    acknowledge to producer
//   out_req_o   request to consumer
//   out_data_o  data to consumer; holds its last value between transfers
//   out_ack_i   consumer acknowledge
//   count_o     words held, including the word currently offered to the consumer
//   full_o      count_o == DEPTH (registered)
//   empty_o     count_o == 0 (registered)

module ctl_hs_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int PROTO       = 0,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_req_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ack_o,
    output logic             out_req_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ack_i,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    // Pointer width kept at least one bit so DEPTH=1 still elaborates.
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam bit            TWO_PH   = (PROTO != 0);

    // ------------------------------------------------------------------
    // Input synchronisers: w_rq / w_ak are the views of the request and
    // acknowledge that the control logic acts on.
    // ------------------------------------------------------------------
    logic w_rq;
    logic w_ak;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_rq = in_req_i;
            assign w_ak = out_ack_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_rq_sync;
            logic [SYNC_STAGES-1:0] r_ak_sync;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rq_sync <= '0;
                    r_ak_sync <= '0;
                end else begin
                    r_rq_sync[0] <= in_req_i;
                    r_ak_sync[0] <= out_ack_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_rq_sync[i] <= r_rq_sync[i-1];
                        r_ak_sync[i] <= r_ak_sync[i-1];
                    end
                end
            end

            assign w_rq = r_rq_sync[SYNC_STAGES-1];
            assign w_ak = r_ak_sync[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_in_ack;
    logic             r_out_req;
    logic [WIDTH-1:0] r_out_data;
    // Set while a word has been issued to the consumer and not yet popped.
    // In 2-phase mode this is what distinguishes "idle after completion"
    // from "idle, nothing outstanding", since both show out_req_o == ak.
    logic             r_busy;

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic          w_push_evt;
    logic          w_push;
    logic          w_release;
    logic          w_out_idle;
    logic          w_pop;
    logic          w_issue;
    logic [CW-1:0] w_count_nxt;

    always_comb begin
        w_push_evt  = 1'b0;
        w_release   = 1'b0;
        w_out_idle  = 1'b0;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_count_nxt = r_count;

        if (TWO_PH) begin
            w_push_evt = (w_rq != r_in_ack);
            w_out_idle = (r_out_req == w_ak);
            w_pop      = w_out_idle && r_busy;
        end else begin
            w_push_evt = w_rq && !r_in_ack;
            w_release  = !w_rq && r_in_ack;
            w_out_idle = !r_out_req && !w_ak;
            w_pop      = r_out_req && w_ak;
        end

        // A pop on the same edge frees the slot, so a push held off by a
        // full buffer completes on exactly that edge.
        w_push  = w_push_evt && ((r_count != DEPTH_C) || w_pop);
        // Issue never coincides with a pop: the next word goes out on the
        // edge after completion.
        w_issue = w_out_idle && !r_busy && (r_count != '0);

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_in_ack   <= 1'b0;
            r_out_req  <= 1'b0;
            r_out_data <= '0;
            r_busy     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            // Producer channel
            if (w_push) begin
                r_in_ack <= TWO_PH ? ~r_in_ack : 1'b1;
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end else if (w_release) begin
                r_in_ack <= 1'b0;
            end

            // Consumer channel
            if (w_issue) begin
                r_out_data <= r_mem[r_rd_ptr];
                r_out_req  <= TWO_PH ? ~r_out_req : 1'b1;
                r_busy     <= 1'b1;
            end else if (w_pop) begin
                r_busy <= 1'b0;
                if (!TWO_PH) begin
                    r_out_req <= 1'b0;
                end
            end

            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end

            // Flags registered from the next count so they never lag count_o.
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign in_ack_o   = r_in_ack;
    assign out_req_o  = r_out_req;
    assign out_data_o = r_out_data;
    assign count_o    = r_count;
    assign full_o     = r_full;
    assign empty_o    = r_empty;

endmodule

// File: tb/tb_ctl_hs_fifo.sv
// Purpose : directed bench for ctl_hs_fifo in three configurations (4-phase S=2 D=4, 2-phase S=0 D=4, 4-phase S=1 D=3).
// Latency : n/a (bench).
// Backpress: n/a (bench).

module tb_ctl_hs_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // ---------------- instance A: 4-phase, S=2, DEPTH=4 ----------------
    logic       rst_a, in_req_a, in_ack_a, out_req_a, out_ack_a, full_a, empty_a;
    logic [7:0] in_data_a, out_data_a;
    logic [2:0] count_a;

    ctl_hs_fifo #(.WIDTH(8), .DEPTH(4), .PROTO(0), .SYNC_STAGES(2)) u_a (
        .clk_i(clk), .rst_ni(rst_a), .in_req_i(in_req_a), .in_data_i(in_data_a),
        .in_ack_o(in_ack_a), .out_req_o(out_req_a), .out_data_o(out_data_a),
        .out_ack_i(out_ack_a), .count_o(count_a), .full_o(full_a), .empty_o(empty_a));

    // ---------------- instance B: 2-phase, S=0, DEPTH=4 ----------------
    logic       rst_bc, in_req_b, in_ack_b, out_req_b, out_ack_b, full_b, empty_b;
    logic [7:0] in_data_b, out_data_b;
    logic [2:0] count_b;

    ctl_hs_fifo #(.WIDTH(8), .DEPTH(4), .PROTO(1), .SYNC_STAGES(0)) u_b (
        .clk_i(clk), .rst_ni(rst_bc), .in_req_i(in_req_b), .in_data_i(in_data_b),
        .in_ack_o(in_ack_b), .out_req_o(out_req_b), .out_data_o(out_data_b),
        .out_ack_i(out_ack_b), .count_o(count_b), .full_o(full_b), .empty_o(empty_b));

    // ---------------- instance C: 4-phase, S=1, DEPTH=3 ----------------
    logic       in_req_c, in_ack_c, out_req_c, out_ack_c, full_c, empty_c;
    logic [7:0] in_data_c, out_data_c;
    logic [1:0] count_c;

    ctl_hs_fifo #(.WIDTH(8), .DEPTH(3), .PROTO(0), .SYNC_STAGES(1)) u_c (
        .clk_i(clk), .rst_ni(rst_bc), .in_req_i(in_req_c), .in_data_i(in_data_c),
        .in_ack_o(in_ack_c), .out_req_o(out_req_c), .out_data_o(out_data_c),
        .out_ack_i(out_ack_c), .count_o(count_c), .full_o(full_c), .empty_o(empty_c));

    localparam int BOUND = 200;

    // ---------------- handshake helpers ----------------
    task automatic a_put(input logic [7:0] d);
        bit ok = 0;
        @(negedge clk); in_data_a = d; in_req_a = 1'b1;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = in_ack_a; end
        if (!ok) tmo("a_put_ack_rise");
        @(negedge clk); in_req_a = 1'b0;
        ok = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = !in_ack_a; end
        if (!ok) tmo("a_put_ack_fall");
    endtask

    task automatic a_get(output logic [7:0] d);
        bit ok = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = out_req_a; end
        if (!ok) tmo("a_get_req_rise");
        d = out_data_a;
        @(negedge clk); out_ack_a = 1'b1;
        ok = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = !out_req_a; end
        if (!ok) tmo("a_get_req_fall");
        @(negedge clk); out_ack_a = 1'b0;
    endtask

    task automatic b_put(input logic [7:0] d);
        bit ok = 0;
        @(negedge clk); in_data_b = d; in_req_b = ~in_req_b;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = (in_ack_b == in_req_b); end
        if (!ok) tmo("b_put_ack");
    endtask

    task automatic b_get(output logic [7:0] d);
        bit ok = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = (out_req_b != out_ack_b); end
        if (!ok) tmo("b_get_req");
        d = out_data_b;
        @(negedge clk); out_ack_b = out_req_b;
    endtask

    task automatic c_put(input logic [7:0] d);
        bit ok = 0;
        @(negedge clk); in_data_c = d; in_req_c = 1'b1;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = in_ack_c; end
        if (!ok) tmo("c_put_ack_rise");
        @(negedge clk); in_req_c = 1'b0;
        ok = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = !in_ack_c; end
        if (!ok) tmo("c_put_ack_fall");
    endtask

    task automatic c_get(output logic [7:0] d);
        bit ok = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = out_req_c; end
        if (!ok) tmo("c_get_req_rise");
        d = out_data_c;
        @(negedge clk); out_ack_c = 1'b1;
        ok = 0;
        for (int i = 0; i < BOUND && !ok; i++) begin @(posedge clk); #1; ok = !out_req_c; end
        if (!ok) tmo("c_get_req_fall");
        @(negedge clk); out_ack_c = 1'b0;
    endtask

    // ---------------- T1 vector table ----------------
    // exp = {in_ack, out_req, out_data[7:0], count[2:0], full, empty}
    typedef struct {
        logic        req;
        logic [7:0]  dat;
        logic        oack;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [7:0]  rx[$];
        logic [2:0]  maxc;
        bit          done;
        int          seen, tog_ack, tog_req, bad;
        bit          saw_full;

        rst_a = 0; rst_bc = 0;
        in_req_a = 0; in_data_a = 0; out_ack_a = 0;
        in_req_b = 0; in_data_b = 0; out_ack_b = 0;
        in_req_c = 0; in_data_c = 0; out_ack_c = 0;

        //             req   dat    oack  {ia,  or,   data,  cnt,  f,    e}
        tbl[0] = '{1'b0, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1}};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, {1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1}};
        tbl[2] = '{1'b1, 8'hA5, 1'b0, {1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1}};
        tbl[3] = '{1'b1, 8'hA5, 1'b0, {1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0}};
        tbl[4] = '{1'b1, 8'hA5, 1'b0, {1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0}};
        tbl[5] = '{1'b0, 8'hA5, 1'b1, {1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0}};
        tbl[6] = '{1'b0, 8'hA5, 1'b1, {1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0}};
        tbl[7] = '{1'b0, 8'hA5, 1'b1, {1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1}};
        tbl[8] = '{1'b0, 8'h00, 1'b0, {1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1}};
        tbl[9] = '{1'b0, 8'h00, 1'b0, {1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1}};

        repeat (3) @(negedge clk);
        rst_a = 1; rst_bc = 1;

        // ---- T1: single word, cycle-exact ----
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_req_a = tbl[i].req; in_data_a = tbl[i].dat; out_ack_a = tbl[i].oack;
            @(posedge clk); #1;
            chk($sformatf("t1_row%0d", i),
                32'({in_ack_a, out_req_a, out_data_a, count_a, full_a, empty_a}),
                32'(tbl[i].exp));
        end

        // ---- T2: fill with consumer stalled, 5th push held then released by a pop ----
        for (int k = 0; k < 4; k++) a_put(8'h10 + 8'(k));
        chk("t2_count_full", 32'(count_a), 32'd4);
        chk("t2_full_flag", 32'(full_a), 32'd1);
        chk("t2_head_offered", 32'({out_req_a, out_data_a}), 32'({1'b1, 8'h10}));
        @(negedge clk); in_data_a = 8'h14; in_req_a = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (in_ack_a) seen++; end
        chk("t2_fifth_withheld", 32'(seen), 32'd0);
        @(negedge clk); out_ack_a = 1'b1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin @(posedge clk); #1; done = in_ack_a; end
        if (!done) tmo("t2_fifth_ack");
        chk("t2_pop_edge_state", 32'({out_req_a, count_a, full_a}), 32'({1'b0, 3'd4, 1'b1}));
        @(negedge clk); out_ack_a = 1'b0; in_req_a = 1'b0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin @(posedge clk); #1; done = !in_ack_a; end
        if (!done) tmo("t2_fifth_release");
        for (int k = 1; k < 5; k++) begin
            a_get(d);
            chk($sformatf("t2_drain%0d", k), 32'(d), 32'h10 + 32'(k));
        end
        @(posedge clk); #1;
        chk("t2_empty_after", 32'({count_a, empty_a}), 32'({3'd0, 1'b1}));

        // ---- T3: streaming 16 words ----
        rx.delete(); maxc = 0; done = 0;
        fork
            begin for (int k = 0; k < 16; k++) a_put(8'(k)); end
            begin
                for (int k = 0; k < 16; k++) begin a_get(d); rx.push_back(d); end
                done = 1;
            end
            begin
                for (int c = 0; c < 5000 && !done; c++) begin
                    @(posedge clk); #1;
                    if (count_a > maxc) maxc = count_a;
                end
            end
        join
        chk("t3_rx_count", 32'(rx.size()), 32'd16);
        for (int k = 0; k < 16 && k < rx.size(); k++)
            chk($sformatf("t3_word%0d", k), 32'(rx[k]), 32'(k));
        chk("t3_max_count_le2", 32'(maxc <= 3'd2), 32'd1);

        // ---- T5: reset mid-transfer ----
        for (int k = 0; k < 3; k++) a_put(8'h21 + 8'(k));
        chk("t5_pre_state", 32'({out_req_a, count_a}), 32'({1'b1, 3'd3}));
        @(negedge clk); #2; rst_a = 1'b0; #1;
        chk("t5_in_reset",
            32'({in_ack_a, out_req_a, out_data_a, count_a, full_a, empty_a}),
            32'({1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1}));
        @(negedge clk); rst_a = 1'b1;
        a_put(8'h3C);
        a_get(d);
        chk("t5_after_data", 32'(d), 32'h3C);
        @(posedge clk); #1;
        chk("t5_after_empty", 32'({count_a, empty_a}), 32'({3'd0, 1'b1}));

        // ---- T4: 2-phase, S=0, words 1,2,3 ----
        rx.delete(); tog_ack = 0; tog_req = 0;
        fork
            begin for (int k = 1; k <= 3; k++) b_put(8'(k)); end
            begin
                repeat (2) @(posedge clk);
                for (int k = 0; k < 3; k++) begin b_get(d); rx.push_back(d); end
            end
            begin
                logic pa, pr;
                pa = in_ack_b; pr = out_req_b;
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk); #1;
                    if (in_ack_b != pa) tog_ack++;
                    if (out_req_b != pr) tog_req++;
                    pa = in_ack_b; pr = out_req_b;
                end
            end
        join
        chk("t4_ack_toggles", 32'(tog_ack), 32'd3);
        chk("t4_req_toggles", 32'(tog_req), 32'd3);
        chk("t4_rx_count", 32'(rx.size()), 32'd3);
        for (int k = 0; k < 3 && k < rx.size(); k++)
            chk($sformatf("t4_word%0d", k), 32'(rx[k]), 32'(k + 1));
        chk("t4_final", 32'({count_b, empty_b}), 32'({3'd0, 1'b1}));

        // ---- T6: DEPTH=3, S=1, 10 words with random gaps ----
        rx.delete(); done = 0; bad = 0; saw_full = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    c_put(8'h40 + 8'(k));
                end
            end
            begin
                repeat (60) @(posedge clk);
                for (int k = 0; k < 10; k++) begin
                    repeat ($urandom_range(0, 8)) @(posedge clk);
                    c_get(d); rx.push_back(d);
                end
                done = 1;
            end
            begin
                for (int c = 0; c < 5000 && !done; c++) begin
                    @(posedge clk); #1;
                    if (full_c != (count_c == 2'd3)) bad++;
                    if (empty_c != (count_c == 2'd0)) bad++;
                    if (full_c) saw_full = 1;
                end
            end
        join
        chk("t6_flag_consistency_errors", 32'(bad), 32'd0);
        chk("t6_reached_full", 32'(saw_full), 32'd1);
        chk("t6_rx_count", 32'(rx.size()), 32'd10);
        for (int k = 0; k < 10 && k < rx.size(); k++)
            chk($sformatf("t6_word%0d", k), 32'(rx[k]), 32'h40 + 32'(k));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
